// File: rtl/serial_addsub_flags.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, with a
// registered Sign/Zero/Carry/Parity/Overflow bank loaded together with Z on done.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  S_IDLE | waiting for start; Z and flags hold the last result
//  S_RUN  | one digit per cycle from the latched operands; done on last
module serial_addsub_flags #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z,
    output logic             Sign,
    output logic             Zero,
    output logic             Carry,
    output logic             Parity,
    output logic             Overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_addsub_flags: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_sub;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT:0]   w_sum;
    logic [WIDTH-1:0] w_res_next;
    logic             w_c_msb_in;
    logic             w_last;

    // Operand shadows shift right one digit per cycle, so the active digit is
    // always the low DIGIT bits; B is stored already inverted for subtraction.
    assign w_a_dig    = r_a[DIGIT-1:0];
    assign w_b_dig    = r_b[DIGIT-1:0];
    assign w_sum      = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
    assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign w_c_msb_in = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_sum[DIGIT-1];
    assign w_last     = (r_cnt == CW'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Z        <= '0;
            Sign     <= 1'b0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Parity   <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= sub ? ~B : B;
                        r_sub   <= sub;
                        r_carry <= sub ? ~Cin : Cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_res   <= w_res_next;
                    r_carry <= w_sum[DIGIT];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        // Carry reports borrow for subtraction, hence the XOR with r_sub.
                        Z        <= w_res_next;
                        Sign     <= w_res_next[WIDTH-1];
                        Zero     <= (w_res_next == '0);
                        Parity   <= ^w_res_next;
                        Carry    <= w_sum[DIGIT] ^ r_sub;
                        Overflow <= w_c_msb_in ^ w_sum[DIGIT];
                        r_cnt    <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_flags.sv
// Bench for serial_addsub_flags: scoreboard of expected results checked on done,
// plus handshake, abort-by-reset and single-digit (DIGIT=WIDTH) latency checks.
module tb_serial_addsub_flags;

    logic        clk = 1'b0;
    logic        rst, start, start16, sub, Cin;
    logic [15:0] A, B;
    logic        busy, done, Sign, Zero, Carry, Parity, Overflow;
    logic [15:0] Z;
    logic        busy16, done16, Sign16, Zero16, Carry16, Parity16, Overflow16;
    logic [15:0] Z16;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [15:0] z;
        logic [4:0]  f;   // {Sign, Zero, Carry, Parity, Overflow}
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] prev_z = 16'h0000;

    always #5 clk = ~clk;

    serial_addsub_flags #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .Z(Z), .Sign(Sign), .Zero(Zero), .Carry(Carry),
        .Parity(Parity), .Overflow(Overflow)
    );

    serial_addsub_flags #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy16), .done(done16), .Z(Z16), .Sign(Sign16), .Zero(Zero16),
        .Carry(Carry16), .Parity(Parity16), .Overflow(Overflow16)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] z, input logic [4:0] f);
        exp_t e;
        e.z = z;
        e.f = f;
        return e;
    endfunction

    // Reference: full-width sum, overflow from operand/result sign rule.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic c);
        logic [15:0] bx;
        logic [16:0] full;
        logic [15:0] z;
        logic        ovf;
        bx   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + {16'h0000, (s ? ~c : c)};
        z    = full[15:0];
        ovf  = (a[15] == bx[15]) && (z[15] != a[15]);
        return mk(z, {z[15], (z == 16'h0000), full[16] ^ s, ^z, ovf});
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                chk_val("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk_val("result_Z", {16'h0000, Z}, {16'h0000, e.z});
                chk_val("flags_SZCPV", {27'd0, Sign, Zero, Carry, Parity, Overflow}, {27'd0, e.f});
                prev_z = e.z;
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen, so a
    // following call starts during the done cycle (back-to-back).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c, input exp_t e);
        int   i;
        logic got_done;
        A = a; B = b; sub = s; Cin = c; start = 1'b1;
        sb_q.push_back(e);
        i = 0;
        got_done = 1'b0;
        while (!got_done && i <= 20) begin
            @(negedge clk);
            i++;
            if (i == 1) begin
                start = 1'b0;
                A = 16'($urandom); B = 16'($urandom);
                sub = 1'($urandom); Cin = 1'($urandom);
                chk_val("done_one_cycle", {31'd0, done}, 32'd0);
            end
            if (i == 2) start = 1'b1;
            if (i == 3) start = 1'b0;
            if (done) begin
                got_done = 1'b1;
            end else begin
                chk_val("busy_in_run", {31'd0, busy}, 32'd1);
                chk_val("z_hold_in_run", {16'h0000, Z}, {16'h0000, prev_z});
            end
        end
        start = 1'b0;
        if (!got_done) chk_val("done_timeout", 32'd0, 32'd1);
        else           chk_val("latency", 32'(i - 1), 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rs, rc;
        rst = 1'b1; start = 1'b0; start16 = 1'b0; sub = 1'b0; Cin = 1'b0;
        A = 16'h0000; B = 16'h0000;
        repeat (3) @(negedge clk);
        chk_val("rst_busy", {31'd0, busy}, 32'd0);
        chk_val("rst_done", {31'd0, done}, 32'd0);
        chk_val("rst_Z", {16'h0000, Z}, 32'd0);
        chk_val("rst_flags", {27'd0, Sign, Zero, Carry, Parity, Overflow}, 32'd0);
        rst = 1'b0;

        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, mk(16'h0000, 5'b01000));
        run_op(16'h8fff, 16'h8000, 1'b0, 1'b0, mk(16'h0fff, 5'b00101));
        run_op(16'hfffe, 16'h0002, 1'b0, 1'b0, mk(16'h0000, 5'b01100));
        run_op(16'haaaa, 16'h5555, 1'b0, 1'b0, mk(16'hffff, 5'b10000));
        run_op(16'haaaa, 16'h5555, 1'b0, 1'b1, mk(16'h0000, 5'b01100));
        run_op(16'h0000, 16'h0001, 1'b1, 1'b0, mk(16'hffff, 5'b10100));
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, mk(16'h7fff, 5'b00011));
        run_op(16'h1234, 16'h0234, 1'b1, 1'b1, mk(16'h0fff, 5'b00000));

        for (int k = 0; k < 6; k++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rs = 1'($urandom);  rc = 1'($urandom);
            run_op(ra, rb, rs, rc, model(ra, rb, rs, rc));
        end

        // Abort after two digits: no done, outputs back to reset values.
        A = 16'h1234; B = 16'h4321; sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk_val("abort_busy", {31'd0, busy}, 32'd0);
        chk_val("abort_done", {31'd0, done}, 32'd0);
        chk_val("abort_Z", {16'h0000, Z}, 32'd0);
        chk_val("abort_flags", {27'd0, Sign, Zero, Carry, Parity, Overflow}, 32'd0);
        rst = 1'b0;
        prev_z = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_val("abort_no_done", {31'd0, done}, 32'd0);
            chk_val("abort_idle", {31'd0, busy}, 32'd0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, mk(16'h0002, 5'b00010));

        // Single-digit instance: done one cycle after start.
        @(negedge clk);
        A = 16'h8fff; B = 16'h8000; sub = 1'b0; Cin = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        chk_val("d16_busy", {31'd0, busy16}, 32'd1);
        chk_val("d16_not_done_yet", {31'd0, done16}, 32'd0);
        @(negedge clk);
        chk_val("d16_done", {31'd0, done16}, 32'd1);
        chk_val("d16_busy_clear", {31'd0, busy16}, 32'd0);
        chk_val("d16_Z", {16'h0000, Z16}, 32'h0000_0fff);
        chk_val("d16_flags", {27'd0, Sign16, Zero16, Carry16, Parity16, Overflow16}, 32'b00101);
        @(negedge clk);
        chk_val("d16_done_pulse", {31'd0, done16}, 32'd0);

        repeat (8) @(negedge clk);
        chk_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
